// File: rtl/bsg_manycore_block_mem_to_link.sv
// bsg_manycore_block_mem_to_link
//   Initiator-side bridge from a block-mem request stream to the manycore
//   link. Requests are decoded into remote loads/stores aimed at the per-column
//   block memories on the top and bottom rows. Stores are pipelined up to
//   out_credits_p outstanding; loads are blocking (one at a time) and their
//   return data is presented on a valid/yumi response port.
//
// Ports
//   clk_i, reset_i        clock, synchronous active-high reset
//   link_sif_i            {ep_ready, return_v, return_type[1:0], return_data}
//   link_sif_o            {return_yumi, packet_v, packet}
//                         packet = {addr, op[1:0], op_ex/mask, reg_id[4:0],
//                                   payload, src_y, src_x, dest_y, dest_x}
//   pkt_i, v_i, ready_o   request {opcode[2:0], byte_addr, data, mask}
//   data_o, v_o, yumi_i   load result stream
//   global_x_i/_y_i       source coordinates written into outgoing packets
//   idle_o                all credits home and no load in flight
//
// Optional feature: define BSG_MANYCORE_BLOCK_MEM_TO_LINK_FENCE_EN to hold
// loads until every outstanding store has been acknowledged.
module bsg_manycore_block_mem_to_link
  #(parameter int link_addr_width_p   = 12
  , parameter int data_width_p        = 32
  , parameter int x_cord_width_p      = 4
  , parameter int y_cord_width_p      = 4
  , parameter int mem_size_in_words_p = 1024
  , parameter int num_tiles_x_p       = 4
  , parameter int top_y_cord_p        = 0
  , parameter int bottom_y_cord_p     = 5
  , parameter int base_x_cord_p       = 0
  , parameter int out_credits_p       = 8
  , parameter int fifo_els_p          = 4
  , localparam int num_blocks_lp          = 2*num_tiles_x_p
  , localparam int block_id_width_lp      = (num_blocks_lp <= 1) ? 1 : $clog2(num_blocks_lp)
  , localparam int words_per_block_lp     = mem_size_in_words_p/num_blocks_lp
  , localparam int word_addr_width_lp     = (words_per_block_lp <= 1) ? 1 : $clog2(words_per_block_lp)
  , localparam int byte_addr_width_lp     = block_id_width_lp + word_addr_width_lp + 2
  , localparam int mask_width_lp          = data_width_p/8
  , localparam int block_mem_pkt_width_lp = 3 + byte_addr_width_lp + data_width_p + mask_width_lp
  , localparam int link_pkt_width_lp      = link_addr_width_p + 2 + mask_width_lp + 5 + data_width_p
                                            + 2*(x_cord_width_p + y_cord_width_p)
  , localparam int link_sif_o_width_lp    = link_pkt_width_lp + 2
  , localparam int link_sif_i_width_lp    = data_width_p + 4
  , localparam int credit_width_lp        = $clog2(out_credits_p+1))
  (input  logic                              clk_i
  , input  logic                              reset_i
  , input  logic [link_sif_i_width_lp-1:0]    link_sif_i
  , output logic [link_sif_o_width_lp-1:0]    link_sif_o
  , input  logic [block_mem_pkt_width_lp-1:0] pkt_i
  , input  logic                              v_i
  , output logic                              ready_o
  , output logic [data_width_p-1:0]           data_o
  , output logic                              v_o
  , input  logic                              yumi_i
  , input  logic [x_cord_width_p-1:0]         global_x_i
  , input  logic [y_cord_width_p-1:0]         global_y_i
  , output logic                              idle_o
  );

  localparam logic [1:0] state_reset_lp     = 2'd0;
  localparam logic [1:0] state_ready_lp     = 2'd1;
  localparam logic [1:0] state_load_wait_lp = 2'd2;
  localparam logic [1:0] state_resp_lp      = 2'd3;

  localparam logic [2:0] op_nop_lp   = 3'd0;
  localparam logic [2:0] op_store_lp = 3'd1;
  localparam logic [2:0] op_lw_lp    = 3'd2;
  localparam logic [2:0] op_lh_lp    = 3'd3;
  localparam logic [2:0] op_lhu_lp   = 3'd4;
  localparam logic [2:0] op_lb_lp    = 3'd5;
  localparam logic [2:0] op_lbu_lp   = 3'd6;

  localparam logic [1:0] link_op_load_lp  = 2'd0;
  localparam logic [1:0] link_op_store_lp = 2'd1;

  localparam logic [1:0] ret_credit_lp   = 2'd0;
  localparam logic [1:0] ret_int_wb_lp   = 2'd1;
  localparam logic [1:0] ret_float_wb_lp = 2'd2;
  localparam logic [1:0] ret_ifetch_lp   = 2'd3;

  localparam logic [credit_width_lp-1:0] credits_max_lp = credit_width_lp'(out_credits_p);

  logic [1:0]                 state_q, state_d;
  logic [credit_width_lp-1:0] credits_q, credits_d;
  logic [data_width_p-1:0]    data_q, data_d;

  logic [2:0]                    opcode;
  logic [byte_addr_width_lp-1:0] byte_addr;
  logic [data_width_p-1:0]       wdata;
  logic [mask_width_lp-1:0]      wmask;
  logic [block_id_width_lp-1:0]  block_id;
  logic [word_addr_width_lp-1:0] word_addr;
  logic [1:0]                    byte_off;

  assign {opcode, byte_addr, wdata, wmask} = pkt_i;
  assign {block_id, word_addr, byte_off}   = byte_addr;

  logic                    ep_ready, ret_v;
  logic [1:0]              ret_type;
  logic [data_width_p-1:0] ret_data;

  assign {ep_ready, ret_v, ret_type, ret_data} = link_sif_i;

  logic is_store, is_load, is_hex, is_byte, is_unsigned;
  assign is_store    = (opcode == op_store_lp);
  assign is_hex      = (opcode == op_lh_lp) | (opcode == op_lhu_lp);
  assign is_byte     = (opcode == op_lb_lp) | (opcode == op_lbu_lp);
  assign is_unsigned = (opcode == op_lhu_lp) | (opcode == op_lbu_lp);
  assign is_load     = (opcode == op_lw_lp) | is_hex | is_byte;

  logic credits_full, credits_avail;
  assign credits_full  = (credits_q == credits_max_lp);
  assign credits_avail = (credits_q != '0);

  logic ready, accept, send;
  always_comb begin
    ready = 1'b0;
    if (state_q == state_ready_lp) begin
      ready = ep_ready & credits_avail;
`ifdef BSG_MANYCORE_BLOCK_MEM_TO_LINK_FENCE_EN
      // A load waits for every prior store to be acknowledged.
      if (is_load) ready = ready & credits_full;
`endif
    end
  end

  assign accept = v_i & ready;
  // Nops are consumed here and never reach the link.
  assign send   = accept & (is_load | is_store);

  logic [link_addr_width_p-1:0] ln_addr;
  logic [1:0]                   ln_op;
  logic [mask_width_lp-1:0]     ln_op_ex;
  logic [data_width_p-1:0]      ln_payload;
  logic [x_cord_width_p-1:0]    dest_x;
  logic [y_cord_width_p-1:0]    dest_y;

  always_comb begin
    ln_addr = '0;
    ln_addr[word_addr_width_lp-1:0] = word_addr;
    if (block_id >= block_id_width_lp'(num_tiles_x_p)) begin
      dest_y = y_cord_width_p'(top_y_cord_p);
      dest_x = x_cord_width_p'(base_x_cord_p) + x_cord_width_p'(block_id)
               - x_cord_width_p'(num_tiles_x_p);
    end else begin
      dest_y = y_cord_width_p'(bottom_y_cord_p);
      dest_x = x_cord_width_p'(base_x_cord_p) + x_cord_width_p'(block_id);
    end
    if (is_store) begin
      ln_op      = link_op_store_lp;
      ln_op_ex   = wmask;
      ln_payload = wdata;
    end else begin
      // load_info = {float_wb, icache_fetch, is_unsigned, is_byte, is_hex, part_sel}
      ln_op           = link_op_load_lp;
      ln_op_ex        = '0;
      ln_payload      = '0;
      ln_payload[6:0] = {1'b0, 1'b0, is_unsigned, is_byte, is_hex, byte_off};
    end
  end

  // Every return is accepted in its arrival cycle.
  assign link_sif_o = {ret_v, send, ln_addr, ln_op, ln_op_ex, 5'b0, ln_payload,
                       global_y_i, global_x_i, dest_y, dest_x};

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    credits_d = credits_q;
    case (state_q)
      state_reset_lp:     state_d = state_ready_lp;
      state_ready_lp:     if (accept & is_load) state_d = state_load_wait_lp;
      state_load_wait_lp: if (ret_v & (ret_type == ret_int_wb_lp)) begin
                            data_d  = ret_data;
                            state_d = state_resp_lp;
                          end
      state_resp_lp:      if (yumi_i) state_d = state_ready_lp;
      default:            state_d = state_reset_lp;
    endcase
    case ({send, ret_v})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= state_reset_lp;
      credits_q <= credits_max_lp;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      data_q    <= data_d;
    end
  end

  assign ready_o = ready;
  assign v_o     = (state_q == state_resp_lp);
  assign data_o  = data_q;
  assign idle_o  = credits_full & (state_q == state_ready_lp);

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(ret_v && ((ret_type == ret_ifetch_lp) || (ret_type == ret_float_wb_lp))))
        else $error("illegal return packet type %0d", ret_type);
      assert (!(ret_v && !send && credits_full))
        else $error("credit counter overflow");
      assert (!(ret_v && (ret_type == ret_credit_lp) && (state_q == state_reset_lp)))
        else $error("credit return during reset state");
    end
    assert ((data_width_p == 32) && (fifo_els_p > 0))
      else $error("unsupported configuration");
  end
`endif

endmodule

// File: tb/tb_bsg_manycore_block_mem_to_link.sv
// Directed bench for bsg_manycore_block_mem_to_link. Outgoing link packets are
// predicted when each request is driven and compared as they appear; load
// results are predicted when the return packet is driven.
module tb_bsg_manycore_block_mem_to_link;

  localparam int NX     = 4;
  localparam int BASE_X = 2;
  localparam int TOP_Y  = 0;
  localparam int BOT_Y  = 5;
  localparam logic [3:0] GX = 4'hA;
  localparam logic [3:0] GY = 4'h3;

  localparam int PKT_W = 51;  // 3 + 12 + 32 + 4
  localparam int LNK_W = 71;  // 12 + 2 + 4 + 5 + 32 + 16
  localparam int LSO_W = LNK_W + 2;
  localparam int LSI_W = 36;

  localparam logic [2:0] OP_NOP = 3'd0, OP_STORE = 3'd1, OP_LW = 3'd2, OP_LH = 3'd3,
                         OP_LHU = 3'd4, OP_LB = 3'd5, OP_LBU = 3'd6;
  localparam logic [1:0] RET_CREDIT = 2'd0, RET_INT_WB = 2'd1;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [LSI_W-1:0] link_sif_i;
  logic [LSO_W-1:0] link_sif_o;
  logic [PKT_W-1:0] pkt_i;
  logic             v_i, ready_o, v_o, yumi_i, idle_o;
  logic [31:0]      data_o;

  logic        ep_ready, ret_v;
  logic [1:0]  ret_type;
  logic [31:0] ret_data;
  logic        ret_yumi, pkt_v;
  logic [LNK_W-1:0] pkt;

  assign link_sif_i = {ep_ready, ret_v, ret_type, ret_data};
  assign {ret_yumi, pkt_v, pkt} = link_sif_o;

  bsg_manycore_block_mem_to_link #(
    .link_addr_width_p(12), .data_width_p(32), .x_cord_width_p(4), .y_cord_width_p(4),
    .mem_size_in_words_p(1024), .num_tiles_x_p(NX), .top_y_cord_p(TOP_Y),
    .bottom_y_cord_p(BOT_Y), .base_x_cord_p(BASE_X), .out_credits_p(8), .fifo_els_p(4)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .link_sif_i(link_sif_i), .link_sif_o(link_sif_o),
    .pkt_i(pkt_i), .v_i(v_i), .ready_o(ready_o), .data_o(data_o), .v_o(v_o),
    .yumi_i(yumi_i), .global_x_i(GX), .global_y_i(GY), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;
  int outstanding = 0;
  logic [LNK_W-1:0] exp_pkt_q[$];
  logic [31:0]      exp_data_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LNK_W-1:0] exp_pkt(input logic [2:0] opc, input int blk,
      input int word, input int off, input logic [31:0] d, input logic [3:0] m);
    logic [3:0] dx, dy;
    logic [1:0] op;
    logic [3:0] ox;
    logic [31:0] pl;
    if (blk >= NX) begin dy = 4'(TOP_Y); dx = 4'(BASE_X + blk - NX); end
    else           begin dy = 4'(BOT_Y); dx = 4'(BASE_X + blk);      end
    if (opc == OP_STORE) begin op = 2'd1; ox = m; pl = d; end
    else begin
      op = 2'd0; ox = 4'd0;
      pl = {25'd0, 2'b00, (opc == OP_LHU || opc == OP_LBU), (opc == OP_LB || opc == OP_LBU),
            (opc == OP_LH || opc == OP_LHU), 2'(off)};
    end
    return {12'(word), op, ox, 5'd0, pl, GY, GX, dy, dx};
  endfunction

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic drive(input logic [2:0] opc, input int blk, input int word, input int off,
                       input logic [31:0] d, input logic [3:0] m, input bit push);
    pkt_i = {opc, 3'(blk), 7'(word), 2'(off), d, m};
    v_i   = 1'b1;
    if (push) exp_pkt_q.push_back(exp_pkt(opc, blk, word, off, d, m));
  endtask

  task automatic drive_store(input int i, input bit push);
    drive(OP_STORE, i % 8, (i * 3) % 128, i % 4, 32'hA500_0000 + 32'(i), 4'((i % 15) + 1), push);
  endtask

  task automatic push_store(input int i);
    exp_pkt_q.push_back(exp_pkt(OP_STORE, i % 8, (i * 3) % 128, i % 4,
                                32'hA500_0000 + 32'(i), 4'((i % 15) + 1)));
  endtask

  task automatic wait_accept(input string tag);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (ready_o === 1'b1) break;
    end
    chk(tag, ready_o, 1'b1);
    if (pkt_i[50:48] != OP_NOP) outstanding++;
    step();
    v_i = 1'b0;
  endtask

  task automatic ret(input logic [1:0] t);
    ret_v = 1'b1; ret_type = t; ret_data = '0;
    @(negedge clk_i);
    chk("ret_yumi", ret_yumi, 1'b1);
    step();
    ret_v = 1'b0;
    outstanding--;
  endtask

  task automatic finish_load(input logic [31:0] rdata);
    logic [31:0] e;
    exp_data_q.push_back(rdata);
    ret_v = 1'b1; ret_type = RET_INT_WB; ret_data = rdata;
    @(negedge clk_i);
    chk("ld_ret_yumi", ret_yumi, 1'b1);
    chk("ld_v_early", v_o, 1'b0);
    step();
    ret_v = 1'b0; ret_data = '0;
    outstanding--;
    e = exp_data_q.pop_front();
    @(negedge clk_i);
    chk("ld_v", v_o, 1'b1);
    chk("ld_data", data_o, e);
    chk("ld_resp_ready", ready_o, 1'b0);
    step();
    @(negedge clk_i);
    chk("ld_v_hold", v_o, 1'b1);
    chk("ld_data_hold", data_o, e);
    step();
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    @(negedge clk_i);
    chk("ld_v_clear", v_o, 1'b0);
    chk("ld_next_ready", ready_o, 1'b1);
    chk("ld_idle", idle_o, outstanding == 0);
    step();
  endtask

  task automatic do_load(input logic [2:0] opc, input int blk, input int word, input int off,
                         input logic [31:0] rdata);
    drive(opc, blk, word, off, 32'h0, 4'h0, 1'b1);
    wait_accept("ld_accept");
    @(negedge clk_i);
    chk("ld_wait_ready", ready_o, 1'b0);
    chk("ld_wait_idle", idle_o, 1'b0);
    step();
    finish_load(rdata);
  endtask

  // Link packet scoreboard.
  always @(negedge clk_i) begin
    if (pkt_v === 1'b1) begin
      if (exp_pkt_q.size() == 0) chk("pkt_unexpected", pkt_v, 1'b0);
      else                       chk("pkt", pkt, exp_pkt_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_acc;
    bit  hit;
    reset_i = 1'b1; v_i = 1'b0; pkt_i = '0; yumi_i = 1'b0;
    ep_ready = 1'b1; ret_v = 1'b0; ret_type = RET_CREDIT; ret_data = '0;
    step(); step();
    @(negedge clk_i);
    chk("rst_ready", ready_o, 1'b0);
    chk("rst_v", v_o, 1'b0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_idle", idle_o, 1'b0);
    step();
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("reset_state_idle", idle_o, 1'b0);
    chk("reset_state_ready", ready_o, 1'b0);
    step();
    @(negedge clk_i);
    chk("ready_after_reset", ready_o, 1'b1);
    chk("idle_after_reset", idle_o, 1'b1);
    step();

    // Store then load to block 0.
    drive(OP_STORE, 0, 0, 0, 32'hDEAD_BEEF, 4'hF, 1'b1);
    wait_accept("st0_accept");
    @(negedge clk_i);
    chk("st0_busy", idle_o, 1'b0);
    step();
    ret(RET_CREDIT);
    do_load(OP_LW, 0, 0, 0, 32'hDEAD_BEEF);

    // Decode corners: first top block, last top block, last bottom block.
    do_load(OP_LBU, NX, 5, 3, 32'h0000_00AB);
    do_load(OP_LH, 7, 127, 2, 32'h0000_BEEF);
    do_load(OP_LB, 3, 64, 1, 32'h0000_007F);

    // Endpoint stall blocks acceptance.
    drive_store(1, 1'b1);
    ep_ready = 1'b0;
    @(negedge clk_i);
    chk("stall_ready", ready_o, 1'b0);
    step();
    ep_ready = 1'b1;
    wait_accept("stall_release");
    ret(RET_CREDIT);

    // Nop is consumed without a packet or a response.
    drive(OP_NOP, 2, 7, 0, 32'h1, 4'h1, 1'b0);
    wait_accept("nop_accept");
    @(negedge clk_i);
    chk("nop_idle", idle_o, 1'b1);
    chk("nop_no_resp", v_o, 1'b0);
    step();

    // Credit exhaustion: 10 cycles of stores, 8 credits.
    n_acc = 0;
    drive_store(0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      hit = (ready_o === 1'b1);
      step();
      if (hit) begin
        n_acc++; outstanding++;
        drive_store(n_acc, n_acc < 8);
      end
    end
    chk("exh_accepted", n_acc, 8);
    @(negedge clk_i);
    chk("exh_ready_low", ready_o, 1'b0);
    step();
    push_store(8);
    ret(RET_CREDIT);
    n_acc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      hit = (ready_o === 1'b1);
      step();
      if (hit) begin
        n_acc++; outstanding++;
        drive_store(8 + n_acc, 1'b0);
      end
    end
    chk("exh_one_more", n_acc, 1);
    v_i = 1'b0;

    // Simultaneous send and return with one credit left.
    ret(RET_CREDIT);
    drive_store(30, 1'b1);
    ret_v = 1'b1; ret_type = RET_CREDIT;
    @(negedge clk_i);
    chk("simul_ready", ready_o, 1'b1);
    chk("simul_ret_yumi", ret_yumi, 1'b1);
    step();
    ret_v = 1'b0; v_i = 1'b0;
    @(negedge clk_i);
    chk("simul_ready_after", ready_o, 1'b1);
    step();
    drive_store(31, 1'b1);
    wait_accept("simul_last_accept");
    @(negedge clk_i);
    chk("simul_drained", ready_o, 1'b0);
    step();
    while (outstanding > 0) ret(RET_CREDIT);
    @(negedge clk_i);
    chk("idle_after_drain", idle_o, 1'b1);
    step();

    // Load behind three outstanding stores.
    for (int i = 40; i < 43; i++) begin
      drive_store(i, 1'b1);
      wait_accept("fence_store_accept");
    end
    drive(OP_LW, 1, 9, 0, 32'h0, 4'h0, 1'b1);
`ifdef BSG_MANYCORE_BLOCK_MEM_TO_LINK_FENCE_EN
    for (int r = 0; r < 3; r++) begin
      @(negedge clk_i);
      chk("fence_hold", ready_o, 1'b0);
      step();
      ret(RET_CREDIT);
    end
    wait_accept("fence_load_accept");
`else
    @(negedge clk_i);
    chk("fence_bypass", ready_o, 1'b1);
    step();
    v_i = 1'b0;
    outstanding++;
    for (int r = 0; r < 3; r++) ret(RET_CREDIT);
`endif
    finish_load(32'h1234_5678);

    // Reset while waiting on a load return.
    drive(OP_LW, 6, 100, 0, 32'h0, 4'h0, 1'b1);
    wait_accept("rst_mid_load_accept");
    @(negedge clk_i);
    chk("rst_mid_wait", ready_o, 1'b0);
    step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    outstanding = 0;
    @(negedge clk_i);
    chk("rst_mid_v", v_o, 1'b0);
    chk("rst_mid_idle_low", idle_o, 1'b0);
    step();
    @(negedge clk_i);
    chk("rst_mid_ready", ready_o, 1'b1);
    chk("rst_mid_idle", idle_o, 1'b1);
    chk("rst_mid_data", data_o, 32'h0);
    chk("rst_mid_v_after", v_o, 1'b0);
    step();

    @(negedge clk_i);
    chk("scoreboard_empty", exp_pkt_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
